// File: rtl/crossroad1_core_switches_db.sv
// Avalon-MM input PIO for the crossroad switch/button bank: per-bit sync,
// debounce, edge capture (W1C) and a maskable level irq.

module crossroad1_core_switches_db_lane #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_sync,
  output logic o_deb,
  output logic o_evt
);
  logic r_sync1, r_sync2, r_deb;
  logic w_deb_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_deb   <= w_deb_nxt;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign w_deb_nxt = r_sync2;
    end else begin : g_count
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] r_cnt, w_cnt_nxt;
      logic          w_take;

      // Any cycle where the input agrees with deb restarts the stability window.
      always_comb begin
        w_take    = 1'b0;
        w_cnt_nxt = '0;
        if (r_sync2 != r_deb) begin
          if (r_cnt == LAST) w_take = 1'b1;
          else               w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      assign w_deb_nxt = w_take ? r_sync2 : r_deb;

      always_ff @(posedge clk) begin
        if (!reset_n) r_cnt <= '0;
        else          r_cnt <= w_cnt_nxt;
      end
    end
  endgenerate

  // Event is flagged on the same edge deb takes its new value.
  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign o_evt = w_deb_nxt & ~r_deb;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign o_evt = ~w_deb_nxt & r_deb;
    end else begin : g_any
      assign o_evt = w_deb_nxt ^ r_deb;
    end
  endgenerate

  assign o_sync = r_sync2;
  assign o_deb  = r_deb;
endmodule

module crossroad1_core_switches_db #(
  parameter int          WIDTH           = 2,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          EDGE_TYPE       = 0,
  parameter logic [31:0] IRQ_RESET_MASK  = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] w_sync, w_deb, w_evt, w_clr;
  logic [WIDTH-1:0] r_mask, r_edge;
  logic [31:0]      r_readdata, w_rd_mux;
  logic             w_wr, w_wr_mask, w_unused_wd;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      crossroad1_core_switches_db_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .EDGE_TYPE      (EDGE_TYPE)
      ) u_lane (
        .clk    (clk),
        .reset_n(reset_n),
        .i_raw  (in_port[gi]),
        .o_sync (w_sync[gi]),
        .o_deb  (w_deb[gi]),
        .o_evt  (w_evt[gi])
      );
    end
  endgenerate

  assign w_wr      = chipselect & ~write_n;
  assign w_wr_mask = w_wr && (address == 2'd2);
  assign w_clr     = (w_wr && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;
  assign w_unused_wd = &{1'b0, writedata};

  always_comb begin
    w_rd_mux = 32'h0;
    case (address)
      2'd0: w_rd_mux = 32'(w_deb);
      2'd1: w_rd_mux = 32'(w_sync);
      2'd2: w_rd_mux = 32'(r_mask);
      2'd3: w_rd_mux = 32'(r_edge);
      default: w_rd_mux = 32'h0;
    endcase
  end

  // A new event overrides a same-cycle clear so no edge is ever lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_readdata <= 32'h0;
      r_mask     <= IRQ_RESET_MASK[WIDTH-1:0];
      r_edge     <= '0;
    end else begin
      r_readdata <= w_rd_mux;
      if (w_wr_mask) r_mask <= writedata[WIDTH-1:0];
      r_edge <= (r_edge & ~w_clr) | w_evt;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge & r_mask);
endmodule

// File: tb/tb_crossroad1_core_switches_db.sv
// Bench for crossroad1_core_switches_db: four builds share one stimulus stream
// and are checked every cycle against a window-based reference model.

module tb_crossroad1_core_switches_db;
  logic        clk;
  logic        reset_n, chipselect, write_n;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd [4];
  logic        irq_o [4];

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // builds: 0 = D4 rise, 1 = D4 any, 2 = D4 fall (mask reset 9), 3 = D0 rise
  crossroad1_core_switches_db #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IRQ_RESET_MASK(32'h0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[0]), .irq(irq_o[0]));
  crossroad1_core_switches_db #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .IRQ_RESET_MASK(32'h0)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[1]), .irq(irq_o[1]));
  crossroad1_core_switches_db #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IRQ_RESET_MASK(32'h9)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[2]), .irq(irq_o[2]));
  crossroad1_core_switches_db #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_RESET_MASK(32'h0)) u3 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[3]), .irq(irq_o[3]));

  function automatic int dcy(input int k);
    return (k == 3) ? 0 : 4;
  endfunction
  function automatic int etype(input int k);
    case (k)
      1: return 2;
      2: return 1;
      default: return 0;
    endcase
  endfunction
  function automatic logic [3:0] rstmask(input int k);
    return (k == 2) ? 4'h9 : 4'h0;
  endfunction

  // reference model state
  logic [3:0]  m_s1 [4], m_s2 [4], m_deb [4], m_edge [4], m_mask [4];
  logic [31:0] m_rd [4];
  logic [3:0]  m_seen [4][8];

  // deb flips once the last D synchronized samples all disagree with it
  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      logic [3:0] nd, ev, clr;
      bit flip;
      if (!reset_n) begin
        m_s1[k] = 4'h0; m_s2[k] = 4'h0; m_deb[k] = 4'h0; m_edge[k] = 4'h0;
        m_mask[k] = rstmask(k); m_rd[k] = 32'h0;
        for (int j = 0; j < 8; j++) m_seen[k][j] = 4'h0;
      end else begin
        case (address)
          2'd0: m_rd[k] = {28'h0, m_deb[k]};
          2'd1: m_rd[k] = {28'h0, m_s2[k]};
          2'd2: m_rd[k] = {28'h0, m_mask[k]};
          default: m_rd[k] = {28'h0, m_edge[k]};
        endcase
        for (int j = 7; j > 0; j--) m_seen[k][j] = m_seen[k][j-1];
        m_seen[k][0] = m_s2[k];
        nd = m_deb[k];
        if (dcy(k) == 0) nd = m_s2[k];
        else begin
          for (int i = 0; i < 4; i++) begin
            flip = 1'b1;
            for (int j = 0; j < dcy(k); j++)
              if (m_seen[k][j][i] == m_deb[k][i]) flip = 1'b0;
            if (flip) nd[i] = ~m_deb[k][i];
          end
        end
        case (etype(k))
          0: ev = nd & ~m_deb[k];
          1: ev = ~nd & m_deb[k];
          default: ev = nd ^ m_deb[k];
        endcase
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
        if (chipselect && !write_n && address == 2'd2) m_mask[k] = writedata[3:0];
        m_edge[k] = (m_edge[k] & ~clr) | ev;
        m_deb[k]  = nd;
        m_s2[k]   = m_s1[k];
        m_s1[k]   = in_port;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (rd[k] !== m_rd[k]) begin
          bad++;
          $display("FAIL model rd u%0d @%0t: got %h want %h", k, $time, rd[k], m_rd[k]);
        end
        total++;
        if (irq_o[k] !== |(m_edge[k] & m_mask[k])) begin
          bad++;
          $display("FAIL model irq u%0d @%0t: got %b want %b", k, $time, irq_o[k], |(m_edge[k] & m_mask[k]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
    writedata = 32'h0; in_port = 4'hF;
    repeat (3) tick();
    chk_en = 1'b1;
    chk("reset rd u0", rd[0], 32'h0);
    chk("reset rd u3", rd[3], 32'h0);

    // held-high switches produce a debounced rise after release
    reset_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 3) chk("d0 data e3", rd[3], 32'h0);
      if (e == 4) chk("d0 data e4", rd[3], 32'hF);
      if (e == 6) chk("data e6", rd[0], 32'h0);
      if (e == 7) chk("data e7", rd[0], 32'hF);
    end
    address = 2'd3;
    tick();
    chk("edge rise", rd[0], 32'hF);
    chk("edge any", rd[1], 32'hF);
    chk("edge fall", rd[2], 32'h0);
    chk("irq masked off", {31'h0, irq_o[0]}, 32'h0);
    in_port = 4'h0;
    repeat (10) tick();
    chk("irq fall reset mask", {31'h0, irq_o[2]}, 32'h1);
    wr(2'd3, 32'hE);
    tick();
    chk("w1c partial", rd[0], 32'h1);

    // short glitch rejected
    address = 2'd0;
    in_port = 4'h2;
    repeat (3) tick();
    in_port = 4'h0;
    repeat (10) tick();
    chk("glitch data", rd[0], 32'h0);
    address = 2'd3;
    tick();
    chk("glitch edge", rd[0], 32'h1);
    chk("glitch edge any", rd[1], 32'h1);

    // accepted pulse raises irq with the edge bit
    wr(2'd2, 32'h2);
    address = 2'd0;
    in_port = 4'h2;
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n == 5) chk("irq before", {31'h0, irq_o[0]}, 32'h0);
      if (n == 6) chk("irq with edge", {31'h0, irq_o[0]}, 32'h1);
      if (n == 6) chk("pulse data n6", rd[0], 32'h0);
      if (n == 7) chk("pulse data n7", rd[0], 32'h2);
    end
    in_port = 4'h0;
    repeat (10) tick();
    chk("irq held", {31'h0, irq_o[0]}, 32'h1);
    wr(2'd3, 32'h2);
    chk("irq cleared", {31'h0, irq_o[0]}, 32'h0);
    tick();
    chk("edge0 kept", rd[0], 32'h1);

    // clear coincides with a new event on the same bit
    wr(2'd2, 32'h4);
    in_port = 4'h4;
    repeat (5) tick();
    wr(2'd3, 32'h4);
    chk("irq event wins", {31'h0, irq_o[0]}, 32'h1);
    tick();
    chk("edge event wins", rd[0], 32'h5);
    wr(2'd3, 32'h4);
    chk("irq after clear", {31'h0, irq_o[0]}, 32'h0);
    in_port = 4'h0;
    repeat (10) tick();

    // edge type builds on bit3
    wr(2'd3, 32'hF);
    in_port = 4'h8;
    repeat (8) tick();
    address = 2'd3;
    tick();
    chk("any rise b3", {31'h0, rd[1][3]}, 32'h1);
    chk("fall rise b3", {31'h0, rd[2][3]}, 32'h0);
    wr(2'd3, 32'hF);
    in_port = 4'h0;
    repeat (8) tick();
    tick();
    chk("any fall b3", {31'h0, rd[1][3]}, 32'h1);
    chk("fall fall b3", {31'h0, rd[2][3]}, 32'h1);

    // bypass build, RAW view, reset mid-debounce
    wr(2'd2, 32'hF);
    in_port = 4'h5;
    address = 2'd0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (n == 3) chk("bypass data n3", rd[3], 32'h0);
      if (n == 4) chk("bypass data n4", rd[3], 32'h5);
    end
    address = 2'd1;
    tick();
    chk("raw d0", rd[3], 32'h5);
    chk("raw d4", rd[0], 32'h5);
    chk("irq bypass", {31'h0, irq_o[3]}, 32'h1);
    reset_n = 1'b0;
    tick();
    chk("irq reset d0", {31'h0, irq_o[3]}, 32'h0);
    chk("irq reset d4", {31'h0, irq_o[0]}, 32'h0);
    reset_n = 1'b1;
    address = 2'd2;
    repeat (2) tick();
    chk("mask reset", rd[3], 32'h0);
    chk("mask reset val", rd[2], 32'h9);
    address = 2'd0;
    repeat (4) tick();
    chk("recount e6", rd[0], 32'h0);
    tick();
    chk("recount e7", rd[0], 32'h5);
    chk("irq stays low", {31'h0, irq_o[3]}, 32'h0);

    // mixed traffic, checked by the model only
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) in_port = 4'($urandom_range(0, 15));
      address = 2'($urandom_range(0, 3));
      writedata = 32'($urandom());
      chipselect = ($urandom_range(0, 4) == 0);
      write_n = ($urandom_range(0, 1) == 0);
      reset_n = ($urandom_range(0, 120) != 0);
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1; reset_n = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
